// File: rtl/fft_input_loader.sv
// fft_input_loader: streams complex samples into the FFT data memory at
// bit-reversed addresses, then hands the memory to the FFT controller with a
// one-cycle start pulse and blocks input until the controller reports done.
module fft_input_loader #(
    parameter int bit_width = 29,
    parameter int IN_W      = 16,
    parameter int N         = 16,
    parameter int SIZE      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_W-1:0]      in_re,
    input  logic signed [IN_W-1:0]      in_im,
    input  logic                        in_last,
    input  logic                        fft_done,
    output logic                        wr_en,
    output logic [SIZE:0]               wr_addr,
    output logic [bit_width-1:0]        wr_re,
    output logic [bit_width-1:0]        wr_im,
    output logic                        flag_start_FFT,
    output logic                        busy,
    output logic                        frame_err
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FLUSH = 2'd1,
        START = 2'd2,
        BUSY  = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [SIZE-1:0]         cnt_r;
    logic                    accept_s;
    logic                    cnt_last_s;
    logic                    wr_en_r;
    logic [SIZE:0]           wr_addr_r;
    logic [bit_width-1:0]    wr_re_r;
    logic [bit_width-1:0]    wr_im_r;
    logic                    frame_err_r;

    // Mirror the index bits so sample k lands where the in-place DIT stages expect it.
    function automatic logic [SIZE-1:0] bitrev(input logic [SIZE-1:0] idx);
        logic [SIZE-1:0] res;
        for (int i = 0; i < SIZE; i++) begin
            res[i] = idx[SIZE-1-i];
        end
        return res;
    endfunction

    // Handshake and end-of-frame decode; in_ready depends on the state register only.
    always_comb begin
        in_ready   = (state_r == LOAD);
        accept_s   = in_valid & in_ready;
        cnt_last_s = (cnt_r == SIZE'(N - 1));
    end

    // Next-state logic: fill a frame, let the last write land, kick the FFT, wait for it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LOAD: begin
                if (accept_s && cnt_last_s) begin
                    state_nxt_s = FLUSH;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            FLUSH: state_nxt_s = START;
            START: state_nxt_s = BUSY;
            BUSY: begin
                if (fft_done) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: state_nxt_s = LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sample counter: restarts after a full frame or an early in_last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {SIZE{1'b0}};
        end else if (accept_s) begin
            if (cnt_last_s || in_last) begin
                cnt_r <= {SIZE{1'b0}};
            end else begin
                cnt_r <= cnt_r + SIZE'(1);
            end
        end
    end

    // Memory write port: strobe for one cycle per accept, data/address hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= {(SIZE + 1){1'b0}};
            wr_re_r   <= {bit_width{1'b0}};
            wr_im_r   <= {bit_width{1'b0}};
        end else begin
            wr_en_r <= accept_s;
            if (accept_s) begin
                wr_addr_r <= {1'b0, bitrev(cnt_r)};
                wr_re_r   <= bit_width'(in_re);
                wr_im_r   <= bit_width'(in_im);
            end
        end
    end

    // Short-frame flag: in_last seen before the frame is complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= accept_s & in_last & ~cnt_last_s;
        end
    end

    assign wr_en          = wr_en_r;
    assign wr_addr        = wr_addr_r;
    assign wr_re          = wr_re_r;
    assign wr_im          = wr_im_r;
    assign frame_err      = frame_err_r;
    assign flag_start_FFT = (state_r == START);
    assign busy           = (state_r != LOAD);

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed self-checking bench for fft_input_loader (N=16).
module tb_fft_input_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        fft_done = 1'b0;
    logic [15:0] in_re = 16'h0000;
    logic [15:0] in_im = 16'h0000;
    logic        in_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [28:0] wr_re;
    logic [28:0] wr_im;
    logic        flag_start_FFT;
    logic        busy;
    logic        frame_err;

    fft_input_loader #(.bit_width(29), .IN_W(16), .N(16), .SIZE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .in_last(in_last), .fft_done(fft_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_re(wr_re), .wr_im(wr_im),
        .flag_start_FFT(flag_start_FFT), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int rev [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    logic [4:0]  cap_addr [$];
    logic [28:0] cap_re [$];
    logic [28:0] cap_im [$];
    int          starts = 0;
    int          errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write/start/error monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                cap_addr.push_back(wr_addr);
                cap_re.push_back(wr_re);
                cap_im.push_back(wr_im);
            end
            if (flag_start_FFT) starts <= starts + 1;
            if (frame_err) errs <= errs + 1;
        end
    end

    function automatic logic [15:0] smp_re(input int k, input bit special);
        if (special && k == 0) return 16'h8000;
        return 16'(k);
    endfunction

    function automatic logic [15:0] smp_im(input int k, input bit special);
        if (special && k == 0) return 16'h7FFF;
        return 16'hFFF0 + 16'(k);
    endfunction

    function automatic logic [28:0] exp_re(input int k, input bit special);
        if (special && k == 0) return 29'h1FFF8000;
        return 29'(k);
    endfunction

    function automatic logic [28:0] exp_im(input int k, input bit special);
        if (special && k == 0) return 29'h00007FFF;
        return 29'h1FFFFFF0 + 29'(k);
    endfunction

    // Offer one sample after up to gap_max idle cycles; returns at the negedge after the accept.
    task automatic push(input logic [15:0] re, input logic [15:0] im, input logic last, input int gap_max);
        int g;
        int t;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        for (int i = 0; i < g; i++) begin
            @(negedge clk);
            chk("idle_wr_en", 32'(wr_en), 32'd0);
        end
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        in_last  = last;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("wr_latency", 32'(wr_en), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int gap_max, input bit special);
        int base;
        int s0;
        base = cap_addr.size();
        s0   = starts;
        for (int k = 0; k < 16; k++) begin
            push(smp_re(k, special), smp_im(k, special), (k == 15), gap_max);
        end
        chk("tail_rdy_lo", 32'(in_ready), 32'd0);
        chk("tail_busy_hi", 32'(busy), 32'd1);
        chk("tail_no_start_yet", 32'(flag_start_FFT), 32'd0);
        @(negedge clk);
        chk("start_pulse", 32'(flag_start_FFT), 32'd1);
        chk("start_no_wr", 32'(wr_en), 32'd0);
        @(negedge clk);
        chk("start_end", 32'(flag_start_FFT), 32'd0);
        chk("busy_run", 32'(busy), 32'd1);
        chk("start_count", 32'(starts), 32'(s0 + 1));
        chk("n_writes", 32'(cap_addr.size() - base), 32'd16);
        if (cap_addr.size() - base == 16) begin
            for (int k = 0; k < 16; k++) begin
                chk($sformatf("addr[%0d]", k), 32'(cap_addr[base + k]), 32'(rev[k]));
                chk($sformatf("re[%0d]", k), 32'(cap_re[base + k]), 32'(exp_re(k, special)));
                chk($sformatf("im[%0d]", k), 32'(cap_im[base + k]), 32'(exp_im(k, special)));
            end
        end
    endtask

    task automatic done_pulse();
        chk("busy_before_done", 32'(busy), 32'd1);
        fft_done = 1'b1;
        @(negedge clk);
        fft_done = 1'b0;
        chk("done_rdy", 32'(in_ready), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_re"}, 32'(wr_re), 32'd0);
        chk({tag, "_im"}, 32'(wr_im), 32'd0);
        chk({tag, "_start"}, 32'(flag_start_FFT), 32'd0);
        chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        int s0;
        int e0;
        int n0;
        #1;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full frame, back-to-back, then hold-off with in_valid high.
        send_frame(0, 1'b0);
        n0 = cap_addr.size();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("holdoff_rdy", 32'(in_ready), 32'd0);
            chk("holdoff_wr", 32'(wr_en), 32'd0);
        end
        in_valid = 1'b0;
        chk("holdoff_nwr", 32'(cap_addr.size()), 32'(n0));
        done_pulse();

        // fft_done while loading changes nothing.
        s0 = starts;
        fft_done = 1'b1;
        @(negedge clk);
        fft_done = 1'b0;
        chk("load_done_rdy", 32'(in_ready), 32'd1);
        chk("load_done_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("load_done_start", 32'(starts), 32'(s0));

        // Gapped frame with sign-extension extremes in the first sample.
        send_frame(1, 1'b1);
        done_pulse();

        // Early in_last on the 5th sample.
        s0 = starts;
        e0 = errs;
        for (int k = 0; k < 5; k++) begin
            push(smp_re(k, 1'b0), smp_im(k, 1'b0), (k == 4), 0);
        end
        chk("early_ferr", 32'(frame_err), 32'd1);
        chk("early_addr", 32'(wr_addr), 32'd2);
        chk("early_rdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("early_ferr_end", 32'(frame_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("early_no_start", 32'(starts), 32'(s0));
        chk("early_err_count", 32'(errs), 32'(e0 + 1));
        send_frame(0, 1'b0);
        done_pulse();

        // Reset after 7 accepts, then a clean frame.
        for (int k = 0; k < 7; k++) begin
            push(smp_re(k, 1'b0), smp_im(k, 1'b0), 1'b0, 0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(0, 1'b0);
        done_pulse();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fft_input_loader.md
# fft_input_loader

Front-end loader for the sequential radix-2 FFT core. Accepts a stream of complex samples over a valid/ready handshake and writes each one into the shared data memory at its bit-reversed address, so the in-place DIT butterflies find their inputs in order. After N samples it issues a one-cycle `flag_start_FFT` pulse to the FFT controller. It then blocks input until the controller reports completion with `fft_done`.

## Interface
- `bit_width`, 29: width of memory words `wr_re`/`wr_im`.
- `IN_W`, 16: width of input samples. Must be ≤ `bit_width`.
- `N`, 16: FFT length. Must equal 2^`SIZE`.
- `SIZE`, 4: log2(N).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  sample present on `in_re`/`in_im`.
- `in_ready`  out  1  loader can accept a sample this cycle.
- `in_re`  in  IN_W  signed real part.
- `in_im`  in  IN_W  signed imaginary part.
- `in_last`  in  1  marks the final sample of a frame.
- `fft_done`  in  1  one-cycle completion pulse from the FFT controller (its `done_o`).
- `wr_en`  out  1  memory write strobe.
- `wr_addr`  out  SIZE+1  memory write address. MSB is always 0.
- `wr_re`  out  bit_width  sign-extended real part.
- `wr_im`  out  bit_width  sign-extended imaginary part.
- `flag_start_FFT`  out  1  one-cycle start pulse to the FFT controller.
- `busy`  out  1  high from FLUSH until the cycle `fft_done` is seen.
- `frame_err`  out  1  one-cycle pulse on an early `in_last`.

## Operation
- States: LOAD, FLUSH, START, BUSY. Reset state is LOAD.
- `in_ready` = (state == LOAD). It is decoded from the state register only, with no combinational path from `in_valid`.
- Accept = `in_valid & in_ready`.
- A sample counter `cnt` (SIZE bits) advances by 1 on every accept.
- On accept, the write-output registers load:
  - `wr_en` = 1.
  - `wr_addr` = {1'b0, bitrev_SIZE(cnt)}.
  - `wr_re` / `wr_im` = input sample sign-extended to `bit_width`. No scaling.
- With no accept, `wr_en` = 0 and `wr_addr`/`wr_re`/`wr_im` hold their values.
- LOAD → FLUSH: on the accept with `cnt` == N-1. `cnt` wraps to 0.
  - `in_last` on this sample is optional; its value is ignored.
- Early `in_last` (accept with `in_last` = 1 and `cnt` != N-1):
  - The sample is still written.
  - `cnt` is cleared to 0 and `frame_err` pulses for 1 cycle.
  - The state stays LOAD and no start is issued. The partial frame is overwritten by the next frame.
- FLUSH → START: unconditional, 1 cycle. This lets the final memory write complete.
- START → BUSY: unconditional. `flag_start_FFT` = 1 during the START cycle only.
- BUSY → LOAD: on `fft_done` = 1. `in_ready` rises the cycle after `fft_done`.
- `fft_done` in LOAD, FLUSH or START is ignored.
- `wr_en` is never asserted in FLUSH, START or BUSY. The FFT core owns the memory port during BUSY.

## Timing
- Reset values (asynchronous, immediate):
  - State LOAD, `cnt` = 0.
  - `in_ready` = 1, `busy` = 0.
  - `wr_en` = 0, `wr_addr` = 0, `wr_re` = 0, `wr_im` = 0.
  - `flag_start_FFT` = 0, `frame_err` = 0.
- Write latency: a sample accepted at cycle t appears with `wr_en` = 1 in cycle t+1.
- Throughput: 1 sample per cycle while `in_valid` stays high. Back-to-back frames are separated by the FFT run plus 1 cycle.
- Last sample accepted at t:
  - t+1: `wr_en` = 1 (last write), `in_ready` = 0, `busy` = 1.
  - t+2: `flag_start_FFT` = 1.
  - t+3 onward: BUSY.
- `fft_done` high at cycle d → `busy` = 0 and `in_ready` = 1 at d+1.
- `frame_err` is high in the cycle after the offending accept, coincident with that sample's `wr_en`.
- Reset asserted mid-frame or mid-FFT discards the partial frame. The loader does not resume; the FFT controller is reset by the same `rst_n`.

## Test plan
- Full frame, N=16: samples re = 0..15 with `in_valid` held high → addresses follow the bit-reversal order 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, 16 consecutive `wr_en` cycles, then `flag_start_FFT` exactly 2 cycles after the 16th accept.
- Sign extension: re = 16'h8000, im = 16'h7FFF → `wr_re` = 29'h1FFF8000, `wr_im` = 29'h00007FFF.
- Gapped `in_valid`, random 50% duty → same address/data sequence, no `wr_en` in idle cycles, `cnt` holds across gaps.
- Early `in_last` on the 5th sample (`cnt` = 4) → write to address 2, `frame_err` pulse, no start pulse; the next 16 samples form a clean frame beginning at address 0.
- Hold-off: after the start pulse, hold `in_valid` = 1 → `in_ready` = 0 and no writes until a `fft_done` pulse, then `in_ready` = 1 the following cycle. A `fft_done` pulse during LOAD has no effect.
- Reset mid-frame after 7 accepts → all outputs at reset values immediately; a following full frame starts at address 0 and behaves as the first case.
